apb2_rr_master: RTL and testbench
=================================

// Module: apb2_rr_master
// PURPOSE
//  Two-port APB2 master that shares one APB slave (dummy_apb2_ram) between two requesters.
//  Round-robin arbitration picks one request at a time; a 3-state FSM drives the APB
//  setup/access phases; the slave's rdata/slverr go back to the winning requester.
//  Sits between core-side masters and the APB RAM. It replaces bench-driven sel/enable.
// PARAMETERS
//  DATA_WIDTH   32   APB data width; a multiple of 8
//  ADDR_WIDTH   8    APB address width
//  PROT         3'b000  constant driven on pprot
//  TIMEOUT      15   max ACCESS cycles waiting for ready; 0 disables the watchdog
// PORTS
//  clk          in   1           clock, rising edge
//  rst_n        in   1           reset; asynchronous assert, active low
//  mN_valid     in   1           request from requester N (N=0,1)
//  mN_ready     out  1           request accepted this cycle
//  mN_write     in   1           1=write, 0=read
//  mN_addr      in   ADDR_WIDTH  target address
//  mN_wdata     in   DATA_WIDTH  write data
//  mN_strb      in   DATA_WIDTH/8  write byte strobes
//  mN_rsp_valid out  1           one-cycle response pulse
//  mN_rdata     out  DATA_WIDTH  read data; valid while mN_rsp_valid
//  mN_slverr    out  1           error flag; valid while mN_rsp_valid
//  psel, penable, pwrite  out  1  APB control
//  paddr        out  ADDR_WIDTH
//  pwdata       out  DATA_WIDTH
//  pstrb        out  DATA_WIDTH/8
//  pprot        out  3
//  prdata       in   DATA_WIDTH
//  pready       in   1
//  pslverr      in   1
// BEHAVIOUR
//  Reset: FSM=IDLE; RR pointer=0 (m0 wins first); all outputs 0 (pprot=PROT).
//  FSM IDLE -> SETUP -> ACCESS -> IDLE.
//   IDLE: if any mN_valid, the arbiter grants one. mN_ready=1 for the winner only (combinational).
//    The winner's write/addr/wdata/strb are registered. Next state is SETUP.
//   SETUP: psel=1, penable=0 for exactly one cycle; next state is ACCESS.
//   ACCESS: psel=1, penable=1; address and control are held stable.
//    pready=1: capture prdata/pslverr; pulse mN_rsp_valid on the next cycle; next state is IDLE.
//  Latency: accept at cycle T -> SETUP T+1 -> ACCESS T+2 -> rsp_valid at T+3 (pready=1 at once).
//  Arbitration: if only one requester is valid, it wins. If both are valid, the pointer side wins.
//   The pointer flips to the loser after each granted transfer. No starvation.
//  Read transfers: pstrb forced to 0 and pwdata held 0. Write transfers: mN_rdata=0 in the response.
//  Outside SETUP/ACCESS: psel=penable=0 and paddr/pwdata/pstrb/pwrite are 0.
//  mN_ready is never asserted outside IDLE. Back-to-back requests have one IDLE cycle between them.
//  Watchdog (TIMEOUT>0): count ACCESS cycles with pready=0.
//   At count==TIMEOUT, end the transfer without pready: slverr=1, rdata=0, psel/penable drop.
//   pready=1 on that same cycle wins: the slave data/err are used.
//  pslverr is forwarded unchanged; no retry.
//  rst_n asserted mid-transfer: outputs clear at once; no response is issued for the aborted transfer.
//  mN_valid dropped after grant: no effect; the latched transfer still completes.
// STRUCTURE
//  Shared header apb2_defs.vh: FSM state codes (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2),
//   PROT bit names (PRIV=0, NONSEC=1, INSTR=2).
//  Sub-module apb2_rr_arbiter: 2-way round robin (req[1:0], advance -> gnt[1:0] one-hot, ptr).
//  Top level holds the FSM, request latch, watchdog counter and response registers.
// TESTING (bench connects the dummy_apb2_ram slave)
//  1 m0 write addr=13 wdata=42 strb=4'hF -> psel at T+1, penable at T+2; m0_rsp_valid at T+3, slverr=0.
//  2 m1 read addr=13 after test 1 -> pstrb=0 during transfer; m1_rdata=42 with m1_rsp_valid.
//  3 m0,m1 valid in the same cycle, three times -> grant order m0,m1,m0; one IDLE cycle between
//    transfers; each response goes only to its own requester.
//  4 Slave stub holds pready=0, TIMEOUT=15 -> 15 ACCESS cycles, then rsp_valid with slverr=1,
//    rdata=0; FSM back to IDLE.
//  5 rst_n low during ACCESS -> psel=penable=0 at once; no rsp_valid; after release, m0 wins first.
//  6 Write strb=4'b0010 wdata=32'hAABBCCDD to addr 5, then read -> only byte 1 becomes 8'hCC.

Source files
------------

// File: rtl/apb2_rr_master_pkg.sv
// Shared definitions for the two-port APB2 round-robin master:
// FSM state codes, pprot bit positions and the watchdog width helper.
package apb2_rr_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int PROT_PRIV   = 0;
    localparam int PROT_NONSEC = 1;
    localparam int PROT_INSTR  = 2;

    // Counter width able to hold TIMEOUT-1 (the last stalled ACCESS cycle index).
    function automatic int wd_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/apb2_rr_arbiter.sv
// Two-way round-robin arbiter: the pointer side wins a tie, and after each
// granted transfer the pointer moves to the requester that did not win.
module apb2_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr_reg;

    always_comb begin
        gnt = 2'b00;
        if (req[ptr_reg]) begin
            gnt[ptr_reg] = 1'b1;
        end else if (req[!ptr_reg]) begin
            gnt[!ptr_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_reg <= gnt[0];
        end
    end

endmodule

// File: rtl/apb2_rr_master.sv
// Two-port APB2 master: round-robin grant, IDLE/SETUP/ACCESS sequencing,
// ACCESS watchdog and per-requester response routing.
module apb2_rr_master
    import apb2_rr_master_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [2:0]  PROT       = 3'b000,
    parameter int          TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_valid,
    output logic                    m0_ready,
    input  logic                    m0_write,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_strb,
    output logic                    m0_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic                    m0_slverr,
    input  logic                    m1_valid,
    output logic                    m1_ready,
    input  logic                    m1_write,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_strb,
    output logic                    m1_rsp_valid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic                    m1_slverr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WD_WIDTH   = wd_width(TIMEOUT);

    apb_state_e state_reg, state_next;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       accept;
    logic       timeout_hit;
    logic       done;

    logic                  owner_reg;
    logic                  write_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0] strb_reg;

    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_strb;

    logic                  rsp_valid_reg;
    logic                  rsp_owner_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  slverr_reg;

    // Requests are only visible to the arbiter while idle, so the pointer
    // advances exactly once per accepted transfer.
    assign req    = (state_reg == ST_IDLE) ? {m1_valid, m0_valid} : 2'b00;
    assign accept = (gnt != 2'b00);

    apb2_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    generate
        if (TIMEOUT > 0) begin : g_wd
            logic [WD_WIDTH-1:0] wd_cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wd_cnt_reg <= '0;
                end else if ((state_reg == ST_ACCESS) && !pready) begin
                    wd_cnt_reg <= wd_cnt_reg + 1'b1;
                end else begin
                    wd_cnt_reg <= '0;
                end
            end

            assign timeout_hit = (state_reg == ST_ACCESS) && !pready &&
                                 (wd_cnt_reg == WD_WIDTH'(TIMEOUT - 1));
        end else begin : g_no_wd
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // A slave ready on the watchdog's last cycle still wins via the pready term.
    assign done = (state_reg == ST_ACCESS) && (pready || timeout_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        psel     = 1'b0;
        penable  = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                m0_ready = gnt[0];
                m1_ready = gnt[1];
            end
            ST_SETUP: begin
                psel = 1'b1;
            end
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: begin
                psel = 1'b0;
            end
        endcase
    end

    assign sel_write = gnt[1] ? m1_write : m0_write;
    assign sel_addr  = gnt[1] ? m1_addr  : m0_addr;
    assign sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
    assign sel_strb  = gnt[1] ? m1_strb  : m0_strb;

    // Read transfers latch zero data/strobes so the bus shows 0 for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg <= 1'b0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            strb_reg  <= '0;
        end else if (accept) begin
            owner_reg <= gnt[1];
            write_reg <= sel_write;
            addr_reg  <= sel_addr;
            wdata_reg <= sel_write ? sel_wdata : '0;
            strb_reg  <= sel_write ? sel_strb  : '0;
        end
    end

    assign pwrite = psel & write_reg;
    assign paddr  = psel ? addr_reg  : '0;
    assign pwdata = psel ? wdata_reg : '0;
    assign pstrb  = psel ? strb_reg  : '0;
    assign pprot  = {PROT[PROT_INSTR], PROT[PROT_NONSEC], PROT[PROT_PRIV]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 1'b0;
            rsp_owner_reg <= 1'b0;
            rdata_reg     <= '0;
            slverr_reg    <= 1'b0;
        end else begin
            rsp_valid_reg <= done;
            if (done) begin
                rsp_owner_reg <= owner_reg;
                rdata_reg     <= (pready && !write_reg) ? prdata : '0;
                slverr_reg    <= pready ? pslverr : 1'b1;
            end
        end
    end

    assign m0_rsp_valid = rsp_valid_reg & ~rsp_owner_reg;
    assign m1_rsp_valid = rsp_valid_reg &  rsp_owner_reg;
    assign m0_rdata     = m0_rsp_valid ? rdata_reg : '0;
    assign m1_rdata     = m1_rsp_valid ? rdata_reg : '0;
    assign m0_slverr    = m0_rsp_valid & slverr_reg;
    assign m1_slverr    = m1_rsp_valid & slverr_reg;

endmodule

// File: tb/tb_apb2_rr_master.sv
// Randomised scoreboard bench for apb2_rr_master with a behavioural APB RAM
// slave (error region at 0xF0..0xFF) and a transaction-level reference model.
module tb_apb2_rr_master;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_valid, m0_ready, m0_write, m0_rsp_valid, m0_slverr;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [SW-1:0] m0_strb;
    logic          m1_valid, m1_ready, m1_write, m1_rsp_valid, m1_slverr;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [SW-1:0] m1_strb;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;

    always #5 clk = ~clk;

    apb2_rr_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PROT(3'b000), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_strb(m0_strb), .m0_rsp_valid(m0_rsp_valid),
        .m0_rdata(m0_rdata), .m0_slverr(m0_slverr),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_strb(m1_strb), .m1_rsp_valid(m1_rsp_valid),
        .m1_rdata(m1_rdata), .m1_slverr(m1_slverr),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          slverr;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mode = 0;       // 0: pready at once, 1: 0..3 wait states, 2: never ready
    int   exp_ptr = 0;
    req_t pend0[$], pend1[$];
    rsp_t exp0[$], exp1[$];
    int   grant_log[$];
    int   acc_cyc_log[$];
    req_t cur0, cur1;
    bit   acc0, acc1;
    logic [DW-1:0] model_mem [256];
    logic [DW-1:0] slave_mem [256];
    int   setup_cyc, access_cyc, access_len, rsp_cyc, waits;
    logic [DW-1:0] last_rdata0, last_rdata1;
    logic last_slverr0, last_slverr1;
    logic psel_q = 1'b0, pen_q = 1'b0;
    rsp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- behavioural APB RAM slave ----------------
    assign prdata  = slave_mem[paddr];
    assign pslverr = psel && penable && (paddr >= 8'hF0);

    initial pready = 1'b0;
    always @(negedge clk) begin
        if (psel && !penable) waits = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
        pready = 1'b0;
        if (psel && penable && mode != 2) begin
            if (waits == 0) pready = 1'b1;
            else waits--;
        end
    end

    always @(posedge clk) begin
        if (psel && penable && pready && pwrite && paddr < 8'hF0)
            for (int b = 0; b < SW; b++)
                if (pstrb[b]) slave_mem[paddr][8*b +: 8] <= pwdata[8*b +: 8];
    end

    // ---------------- reference model ----------------
    task automatic model_accept(input req_t r, input int port);
        rsp_t x;
        logic err;
        err = (r.addr >= 8'hF0);
        if (mode == 2) begin
            x = '{rdata: '0, slverr: 1'b1};
        end else if (r.wr) begin
            if (!err)
                for (int b = 0; b < SW; b++)
                    if (r.strb[b]) model_mem[r.addr][8*b +: 8] = r.wdata[8*b +: 8];
            x = '{rdata: '0, slverr: err};
        end else begin
            x = '{rdata: model_mem[r.addr], slverr: err};
        end
        if (port == 0) exp0.push_back(x);
        else exp1.push_back(x);
    endtask

    // ---------------- request driver ----------------
    initial begin
        int w;
        m0_valid = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0; m0_strb = '0;
        m1_valid = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0; m1_strb = '0;
        forever begin
            @(negedge clk);
            acc0 = m0_valid && m0_ready;
            acc1 = m1_valid && m1_ready;
            if (acc0 || acc1) begin
                check("single_grant", {31'b0, acc0 && acc1}, 0);
                w = (m0_valid && m1_valid) ? exp_ptr : (m0_valid ? 0 : 1);
                check("grant_winner", {31'b0, acc1}, w);
                grant_log.push_back(acc1 ? 1 : 0);
                acc_cyc_log.push_back(cyc);
                $display("accept m%0d cyc=%0d wr=%0d addr=%h", w, cyc, acc1 ? cur1.wr : cur0.wr,
                         acc1 ? cur1.addr : cur0.addr);
                model_accept(w == 1 ? cur1 : cur0, w);
                exp_ptr = 1 - w;
            end
            @(posedge clk);
            #1;
            if (acc0) m0_valid = 0;
            if (acc1) m1_valid = 0;
            if (!m0_valid && pend0.size() > 0) begin
                cur0 = pend0.pop_front();
                m0_valid = 1; m0_write = cur0.wr; m0_addr = cur0.addr;
                m0_wdata = cur0.wdata; m0_strb = cur0.strb;
            end
            if (!m1_valid && pend1.size() > 0) begin
                cur1 = pend1.pop_front();
                m1_valid = 1; m1_write = cur1.wr; m1_addr = cur1.addr;
                m1_wdata = cur1.wdata; m1_strb = cur1.strb;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (psel && !psel_q) begin
                setup_cyc = cyc;
                check("setup_penable", {31'b0, penable}, 0);
                if (!pwrite) begin
                    check("read_pstrb", {28'b0, pstrb}, 0);
                    check("read_pwdata", pwdata, 0);
                end
            end
            if (penable && !pen_q) begin
                access_cyc = cyc;
                access_len = 0;
            end
            if (penable) access_len++;
            if (m0_ready || m1_ready) check("ready_outside_idle", {31'b0, psel}, 0);
            if (m0_rsp_valid && m1_rsp_valid) check("dual_rsp", 1, 0);
            if (m0_rsp_valid) begin
                rsp_cyc = cyc;
                last_rdata0 = m0_rdata; last_slverr0 = m0_slverr;
                $display("rsp m0 cyc=%0d rdata=%h slverr=%0d", cyc, m0_rdata, m0_slverr);
                if (exp0.size() == 0) begin
                    check("unexpected_rsp_m0", 1, 0);
                end else begin
                    e = exp0.pop_front();
                    check("m0_rdata", m0_rdata, e.rdata);
                    check("m0_slverr", {31'b0, m0_slverr}, {31'b0, e.slverr});
                end
            end
            if (m1_rsp_valid) begin
                rsp_cyc = cyc;
                last_rdata1 = m1_rdata; last_slverr1 = m1_slverr;
                $display("rsp m1 cyc=%0d rdata=%h slverr=%0d", cyc, m1_rdata, m1_slverr);
                if (exp1.size() == 0) begin
                    check("unexpected_rsp_m1", 1, 0);
                end else begin
                    e = exp1.pop_front();
                    check("m1_rdata", m1_rdata, e.rdata);
                    check("m1_slverr", {31'b0, m1_slverr}, {31'b0, e.slverr});
                end
            end
        end
        psel_q = psel;
        pen_q  = penable;
    end

    task automatic wait_idle(input int max_cycles, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clk);
            #1;
            if (pend0.size() == 0 && pend1.size() == 0 && !m0_valid && !m1_valid &&
                exp0.size() == 0 && exp1.size() == 0 && !psel)
                ok = 1;
        end
        check({"drain_", name}, {31'b0, ok}, 1);
    endtask

    function automatic req_t mk(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] s);
        return '{wr: wr, addr: a, wdata: d, strb: s};
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int n;
        bit seen;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
            slave_mem[i] = (i * 32'h01010101) ^ 32'h5A5A0000;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_psel", {31'b0, psel}, 0);
        check("reset_penable", {31'b0, penable}, 0);
        check("reset_paddr", {24'b0, paddr}, 0);
        check("reset_pprot", {29'b0, pprot}, 0);
        check("reset_rsp", {30'b0, m1_rsp_valid, m0_rsp_valid}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // 1: m0 write, latency
        pend0.push_back(mk(1, 8'd13, 32'd42, 4'hF));
        wait_idle(50, "t1");
        n = acc_cyc_log.size() - 1;
        check("t1_setup_lat", setup_cyc, acc_cyc_log[n] + 1);
        check("t1_access_lat", access_cyc, acc_cyc_log[n] + 2);
        check("t1_rsp_lat", rsp_cyc, acc_cyc_log[n] + 3);
        check("t1_slverr", {31'b0, last_slverr0}, 0);

        // 2: m1 reads back
        pend1.push_back(mk(0, 8'd13, 32'hFFFFFFFF, 4'hF));
        wait_idle(50, "t2");
        check("t2_rdata", last_rdata1, 32'd42);

        // 3: simultaneous requests alternate
        n = grant_log.size();
        for (int k = 0; k < 3; k++) begin
            pend0.push_back(mk(0, 8'(20 + k), 32'h0, 4'h0));
            pend1.push_back(mk(1, 8'(30 + k), 32'(k * 7 + 1), 4'hF));
        end
        wait_idle(200, "t3");
        for (int k = 0; k < 3; k++) check("t3_order", grant_log[n + k], k % 2);
        for (int k = 1; k < 3; k++) check("t3_spacing", acc_cyc_log[n + k] - acc_cyc_log[n + k - 1], 3);

        // 4: watchdog
        mode = 2;
        pend1.push_back(mk(0, 8'd40, 32'h0, 4'h0));
        wait_idle(100, "t4");
        check("t4_access_len", access_len, 15);
        check("t4_slverr", {31'b0, last_slverr1}, 1);
        check("t4_rdata", last_rdata1, 0);

        // 5: reset during ACCESS
        pend0.push_back(mk(0, 8'd7, 32'h0, 4'h0));
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (penable) seen = 1;
        end
        check("t5_reach_access", {31'b0, seen}, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        m0_valid = 0; m1_valid = 0;
        exp0.delete(); exp1.delete(); pend0.delete(); pend1.delete();
        exp_ptr = 0;
        #1;
        check("t5_psel_clear", {31'b0, psel}, 0);
        check("t5_penable_clear", {31'b0, penable}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t5_no_rsp", {30'b0, m1_rsp_valid, m0_rsp_valid}, 0);
        mode = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        n = grant_log.size();
        pend0.push_back(mk(0, 8'd8, 32'h0, 4'h0));
        pend1.push_back(mk(0, 8'd9, 32'h0, 4'h0));
        wait_idle(100, "t5");
        check("t5_first_winner", grant_log[n], 0);

        // 6: byte strobes
        pend0.push_back(mk(1, 8'd5, 32'h11223344, 4'hF));
        pend0.push_back(mk(1, 8'd5, 32'hAABBCCDD, 4'b0010));
        pend0.push_back(mk(0, 8'd5, 32'h0, 4'h0));
        wait_idle(100, "t6");
        check("t6_strobe_merge", last_rdata0, 32'h1122CC44);

        // random traffic with wait states and error region
        mode = 1;
        for (int i = 0; i < 60; i++) begin
            req_t r;
            r = mk(1'($urandom), 8'($urandom_range(0, 255)), $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 1) pend1.push_back(r);
            else pend0.push_back(r);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
        end
        wait_idle(3000, "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
